// File: rtl/uart_tx_multi.sv
// Buffered UART transmitter: a word FIFO feeding a fixed-format serial framer
// (5-9 data bits LSB first, optional even/odd parity, 1 or 2 stop bits) with line-break generation.
module uart_tx_multi #(
    parameter int CLK_IN    = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_BITS-1:0]   din,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] data_count,
    input  logic                   break_en,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);
    localparam int DIV   = CLK_IN / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   FIFO_ONE  = (PTR_W + 1)'(1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [3:0]       IDX_ONE   = 4'd1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_multi: CLK_IN/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_tx_multi: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_multi: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_multi: STOP_BITS must be 1 or 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_multi: DEPTH must be a power of 2, >= 2");
    end

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~^d : ^d;
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count;
    logic [DATA_BITS-1:0] rd_data;
    logic                 push, pop;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_bit, par_n;
    logic                 tx_n, busy_n, done_n;
    logic                 tick, load;

    assign push       = wr_en && !full;
    assign pop        = load;
    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign data_count = count;
    assign rd_data    = mem[rd_ptr];
    assign tick       = (cnt == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + FIFO_ONE;
                2'b01:   count <= count - FIFO_ONE;
                default: count <= count;
            endcase
        end
    end

    // tx/busy/done are registered, so the line shows each state one cycle after the FSM enters it
    always_comb begin
        state_n = state;
        idx_n   = idx;
        shift_n = shift;
        par_n   = par_bit;
        tx_n    = 1'b1;
        busy_n  = 1'b1;
        done_n  = 1'b0;
        load    = 1'b0;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (break_en) state_n = S_BREAK;
                else if (!empty) load = 1'b1;
            end
            S_START: begin
                tx_n = 1'b0;
                if (tick) begin
                    state_n = S_DATA;
                    idx_n   = '0;
                end
            end
            S_DATA: begin
                tx_n = shift[0];
                if (tick) begin
                    shift_n = shift >> 1;
                    if (idx == LAST_DATA) begin
                        state_n = (PARITY != 0) ? S_PAR : S_STOP;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IDX_ONE;
                    end
                end
            end
            S_PAR: begin
                tx_n = par_bit;
                if (tick) begin
                    state_n = S_STOP;
                    idx_n   = '0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (idx == LAST_STOP) begin
                        done_n = 1'b1;
                        // Chain straight into the next start bit when more data is waiting
                        if (!break_en && !empty) load = 1'b1;
                        else state_n = S_IDLE;
                    end else begin
                        idx_n = idx + IDX_ONE;
                    end
                end
            end
            S_BREAK: begin
                tx_n = !break_en;
                if (!break_en && tick) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (load) begin
            state_n = S_START;
            shift_n = rd_data;
            par_n   = parity_of(rd_data);
        end
        // Holding break re-arms the counter so mark-after-break always lasts a full bit
        if (state_n != state || tick || state == S_IDLE || (state == S_BREAK && break_en))
            cnt_n = RELOAD;
        else
            cnt_n = cnt - CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= RELOAD;
            idx   <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            tx    <= tx_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_ff @(posedge clk) begin
        shift   <= shift_n;
        par_bit <= par_n;
    end
endmodule

// File: tb/tb_uart_tx_multi.sv
// Bench for uart_tx_multi: three frame formats driven in lockstep and compared every cycle
// against a frame-schedule model, plus literal checks of the documented timing cases.
module tb_uart_tx_multi;
    localparam int CLK_IN = 16;
    localparam int BAUD   = 4;
    localparam int DIV    = CLK_IN / BAUD;
    localparam int NI     = 3;
    localparam int DBITS  [NI] = '{8, 7, 9};
    localparam int PARS   [NI] = '{0, 1, 2};
    localparam int STOPS  [NI] = '{1, 2, 1};
    localparam int DEPTHS [NI] = '{4, 8, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [8:0] din_w;
    logic       break_en;

    logic       full_a, empty_a, tx_a, busy_a, done_a;
    logic       full_b, empty_b, tx_b, busy_b, done_b;
    logic       full_c, empty_c, tx_c, busy_c, done_c;
    logic [2:0] dc_a;
    logic [3:0] dc_b;
    logic [1:0] dc_c;

    int total = 0;
    int bad   = 0;

    // Reference model state, one slot per instance
    logic [8:0] mq_data [NI][16];
    int         mq_head [NI];
    int         mq_cnt  [NI];
    logic       fb      [NI][16];
    int         flen    [NI];
    int         fpos    [NI];
    bit         frame_on[NI];
    bit         in_brk  [NI];
    int         mab     [NI];
    logic       e_tx    [NI];
    logic       e_busy  [NI];
    logic       e_done  [NI];

    always #5 clk = ~clk;

    uart_tx_multi #(.CLK_IN(CLK_IN), .BAUD(BAUD), .DATA_BITS(DBITS[0]), .PARITY(PARS[0]),
                    .STOP_BITS(STOPS[0]), .DEPTH(DEPTHS[0])) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din_w[7:0]), .full(full_a), .empty(empty_a),
        .data_count(dc_a), .break_en(break_en), .tx(tx_a), .busy(busy_a), .done(done_a));

    uart_tx_multi #(.CLK_IN(CLK_IN), .BAUD(BAUD), .DATA_BITS(DBITS[1]), .PARITY(PARS[1]),
                    .STOP_BITS(STOPS[1]), .DEPTH(DEPTHS[1])) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din_w[6:0]), .full(full_b), .empty(empty_b),
        .data_count(dc_b), .break_en(break_en), .tx(tx_b), .busy(busy_b), .done(done_b));

    uart_tx_multi #(.CLK_IN(CLK_IN), .BAUD(BAUD), .DATA_BITS(DBITS[2]), .PARITY(PARS[2]),
                    .STOP_BITS(STOPS[2]), .DEPTH(DEPTHS[2])) dut_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din_w), .full(full_c), .empty(empty_c),
        .data_count(dc_c), .break_en(break_en), .tx(tx_c), .busy(busy_c), .done(done_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mq_head[i]  = 0;
            mq_cnt[i]   = 0;
            frame_on[i] = 1'b0;
            in_brk[i]   = 1'b0;
            mab[i]      = 0;
            fpos[i]     = 0;
            flen[i]     = 0;
            e_tx[i]     = 1'b1;
            e_busy[i]   = 1'b0;
            e_done[i]   = 1'b0;
        end
    endtask

    // Lay out one frame as a bit list: start, data LSB first, optional parity, stop bit(s)
    task automatic start_frame(input int i, input logic [8:0] w);
        int   n;
        logic p;
        n = 0;
        p = 1'b0;
        fb[i][n] = 1'b0;
        n++;
        for (int b = 0; b < DBITS[i]; b++) begin
            fb[i][n] = w[b];
            p = p ^ w[b];
            n++;
        end
        if (PARS[i] != 0) begin
            fb[i][n] = (PARS[i] == 2) ? ~p : p;
            n++;
        end
        for (int s = 0; s < STOPS[i]; s++) begin
            fb[i][n] = 1'b1;
            n++;
        end
        flen[i]     = n * DIV;
        fpos[i]     = 0;
        frame_on[i] = 1'b1;
    endtask

    // Advance one clock edge: expected line values after the edge, then FIFO pop/push
    task automatic model_step(input int i);
        int         pre;
        bit         do_pop;
        logic [8:0] w;
        pre    = mq_cnt[i];
        do_pop = 1'b0;
        if (frame_on[i]) begin
            e_tx[i]   = fb[i][fpos[i] / DIV];
            e_busy[i] = 1'b1;
            e_done[i] = (fpos[i] == flen[i] - 1);
            fpos[i]++;
            if (fpos[i] == flen[i]) begin
                frame_on[i] = 1'b0;
                do_pop = !break_en && (pre > 0);
            end
        end else if (in_brk[i]) begin
            e_busy[i] = 1'b1;
            e_done[i] = 1'b0;
            if (break_en) begin
                e_tx[i] = 1'b0;
                mab[i]  = DIV;
            end else begin
                e_tx[i] = 1'b1;
                mab[i]--;
                if (mab[i] == 0) in_brk[i] = 1'b0;
            end
        end else begin
            e_tx[i]   = 1'b1;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
            if (break_en) begin
                in_brk[i] = 1'b1;
                mab[i]    = DIV;
            end else begin
                do_pop = (pre > 0);
            end
        end
        if (do_pop) begin
            w = mq_data[i][mq_head[i]];
            mq_head[i] = (mq_head[i] + 1) % 16;
            mq_cnt[i]--;
            start_frame(i, w);
        end
        if (wr_en && pre < DEPTHS[i]) begin
            mq_data[i][(mq_head[i] + mq_cnt[i]) % 16] = din_w & 9'((1 << DBITS[i]) - 1);
            mq_cnt[i]++;
        end
    endtask

    task automatic compare_all();
        chk("a_tx", tx_a, e_tx[0]);
        chk("a_busy", busy_a, e_busy[0]);
        chk("a_done", done_a, e_done[0]);
        chk("a_full", full_a, mq_cnt[0] == DEPTHS[0]);
        chk("a_empty", empty_a, mq_cnt[0] == 0);
        chk("a_count", dc_a, mq_cnt[0]);
        chk("b_tx", tx_b, e_tx[1]);
        chk("b_busy", busy_b, e_busy[1]);
        chk("b_done", done_b, e_done[1]);
        chk("b_full", full_b, mq_cnt[1] == DEPTHS[1]);
        chk("b_empty", empty_b, mq_cnt[1] == 0);
        chk("b_count", dc_b, mq_cnt[1]);
        chk("c_tx", tx_c, e_tx[2]);
        chk("c_busy", busy_c, e_busy[2]);
        chk("c_done", done_c, e_done[2]);
        chk("c_full", full_c, mq_cnt[2] == DEPTHS[2]);
        chk("c_empty", empty_c, mq_cnt[2] == 0);
        chk("c_count", dc_c, mq_cnt[2]);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else for (int i = 0; i < NI; i++) model_step(i);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_outputs();
        chk("rst_tx", {tx_a, tx_b, tx_c}, 3'b111);
        chk("rst_busy", {busy_a, busy_b, busy_c}, 3'b000);
        chk("rst_done", {done_a, done_b, done_c}, 3'b000);
        chk("rst_full", {full_a, full_b, full_c}, 3'b000);
        chk("rst_empty", {empty_a, empty_b, empty_c}, 3'b111);
        chk("rst_count", {dc_a, dc_b, dc_c}, 9'd0);
    endtask

    // Called at a falling edge; reset rises mid-cycle and must act before any clock edge
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        model_reset();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_cnt, done_at_a, done_at_b, done_at_c;
        bit prev_done;
        int wr_pct, brk_timer;

        rst = 1'b1;
        wr_en = 1'b0;
        din_w = '0;
        break_en = 1'b0;
        model_reset();
        step();
        check_reset_outputs();
        step();
        rst = 1'b0;
        repeat (3) step();

        // Single 0x55 word from idle
        wr_en = 1'b1;
        din_w = 9'h055;
        step();
        wr_en = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at_a = 0; done_at_b = 0; done_at_c = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k >= 2 && k <= 41) chk("t1_tx_a", tx_a, ((k - 2) / 4) % 2);
            busy_cnt += int'(busy_a);
            if (done_a) begin done_cnt++; done_at_a = k; end
            if (done_b) done_at_b = k;
            if (done_c) done_at_c = k;
        end
        chk("t1_busy_cycles_a", busy_cnt, 40);
        chk("t1_done_pulses_a", done_cnt, 1);
        chk("t1_done_at_a", done_at_a, 41);
        chk("t1_done_at_b", done_at_b, 45);
        chk("t1_done_at_c", done_at_c, 49);

        // Parity of 0x03: even gives 0, odd gives 1
        wr_en = 1'b1;
        din_w = 9'h003;
        step();
        wr_en = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k >= 34 && k <= 37) chk("t2_even_par_b", tx_b, 0);
            if (k >= 42 && k <= 45) chk("t2_odd_par_c", tx_c, 1);
        end

        // Fill past capacity while break is held, then release
        break_en = 1'b1;
        repeat (2) step();
        for (int n = 0; n < 5; n++) begin
            wr_en = 1'b1;
            din_w = 9'($urandom);
            step();
        end
        wr_en = 1'b0;
        chk("t3_full_a", full_a, 1);
        chk("t3_count_a", dc_a, 4);
        chk("t3_break_tx_a", tx_a, 0);
        repeat (6) step();
        break_en = 1'b0;
        done_cnt = 0;
        prev_done = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            step();
            if (prev_done && done_cnt < 4) chk("t3_back_to_back_a", tx_a, 0);
            prev_done = done_a;
            if (done_a) done_cnt++;
        end
        chk("t3_frames_a", done_cnt, 4);
        chk("t3_drained_a", empty_a, 1);

        // Reset in the middle of the data bits
        for (int n = 0; n < 3; n++) begin
            wr_en = 1'b1;
            din_w = 9'($urandom);
            step();
        end
        wr_en = 1'b0;
        repeat (12) step();
        pulse_reset();
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            busy_cnt += int'(busy_a) + int'(busy_b) + int'(busy_c);
        end
        chk("t5_no_frame_after_reset", busy_cnt, 0);

        // Break raised while a frame is on the line and another is queued
        for (int n = 0; n < 2; n++) begin
            wr_en = 1'b1;
            din_w = 9'($urandom);
            step();
        end
        wr_en = 1'b0;
        repeat (12) step();
        break_en = 1'b1;
        repeat (70) step();
        chk("t6_not_popped_a", dc_a, 1);
        chk("t6_break_tx_a", tx_a, 0);
        chk("t6_break_busy_a", busy_a, 1);
        break_en = 1'b0;
        repeat (150) step();

        // Randomised traffic with occasional breaks and resets
        wr_pct = 30;
        brk_timer = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 256 == 0) begin
                case ($urandom_range(0, 2))
                    0:       wr_pct = 5;
                    1:       wr_pct = 30;
                    default: wr_pct = 80;
                endcase
            end
            wr_en = ($urandom_range(0, 99) < wr_pct);
            din_w = 9'($urandom);
            if (brk_timer > 0) begin
                brk_timer--;
            end else if (break_en) begin
                break_en = 1'b0;
                brk_timer = 8 + $urandom_range(0, 20);
            end else if ($urandom_range(0, 199) == 0) begin
                break_en = 1'b1;
                brk_timer = $urandom_range(1, 40);
            end
            if ($urandom_range(0, 999) == 0) pulse_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
